// File: rtl/mult_fu_if.sv
// Issue, result and control bundle between issue logic / CDB and the multiply unit.
// The unit itself connects through the slave modport.
interface mult_fu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             issue_valid;
    logic             issue_ready;
    logic [XLEN-1:0]  opa;
    logic [XLEN-1:0]  opb;
    logic [1:0]       func;
    logic [TAG_W-1:0] rob_tag_in;
    logic             squash;
    logic             ack;
    logic             done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] rob_tag_out;

    modport master (
        output issue_valid, opa, opb, func, rob_tag_in, squash, ack,
        input  issue_ready, done, result, rob_tag_out
    );

    modport slave (
        input  issue_valid, opa, opb, func, rob_tag_in, squash, ack,
        output issue_ready, done, result, rob_tag_out
    );
endinterface

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: STAGES chunked partial-product stages feeding an
// OUT_DEPTH result FIFO whose head is offered to the CDB with a done/ack handshake.
module mult_fu #(
    parameter int XLEN      = 32,
    parameter int STAGES    = 4,
    parameter int TAG_W     = 5,
    parameter int OUT_DEPTH = 2
) (
    input  logic     clock,
    input  logic     reset_n,
    mult_fu_if.slave bus
);
    localparam int PW    = 2 * XLEN;
    localparam int CHUNK = PW / STAGES;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    localparam logic [1:0] FUNC_MUL    = 2'b00;
    localparam logic [1:0] FUNC_MULH   = 2'b01;
    localparam logic [1:0] FUNC_MULHSU = 2'b10;

    logic          a_signed;
    logic          b_signed;
    logic [PW-1:0] opa_ext;
    logic [PW-1:0] opb_ext;

    assign a_signed = (bus.func == FUNC_MULH) || (bus.func == FUNC_MULHSU);
    assign b_signed = (bus.func == FUNC_MULH);
    assign opa_ext  = {{XLEN{a_signed & bus.opa[XLEN-1]}}, bus.opa};
    assign opb_ext  = {{XLEN{b_signed & bus.opb[XLEN-1]}}, bus.opb};

    // Stage s holds the state after s+1 chunk steps have been applied.
    logic             valid_reg  [STAGES];
    logic [TAG_W-1:0] tag_reg    [STAGES];
    logic [1:0]       func_reg   [STAGES];
    logic [PW-1:0]    prod_reg   [STAGES];
    logic [PW-1:0]    mcand_reg  [STAGES];
    logic [PW-1:0]    mplier_reg [STAGES];

    logic [PW-1:0]    prod_next   [STAGES];
    logic [PW-1:0]    mcand_next  [STAGES];
    logic [PW-1:0]    mplier_next [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_step
            logic [PW-1:0] prod_in;
            logic [PW-1:0] mcand_in;
            logic [PW-1:0] mplier_in;

            if (gi == 0) begin : g_first
                assign prod_in   = '0;
                assign mcand_in  = opa_ext;
                assign mplier_in = opb_ext;
            end else begin : g_rest
                assign prod_in   = prod_reg[gi-1];
                assign mcand_in  = mcand_reg[gi-1];
                assign mplier_in = mplier_reg[gi-1];
            end

            assign prod_next[gi]   = prod_in + mcand_in * PW'(mplier_in[CHUNK-1:0]);
            assign mcand_next[gi]  = mcand_in << CHUNK;
            assign mplier_next[gi] = mplier_in >> CHUNK;
        end
    endgenerate

    logic [XLEN-1:0]  q_result_reg [OUT_DEPTH];
    logic [TAG_W-1:0] q_tag_reg    [OUT_DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic            last_valid;
    logic            q_full;
    logic            q_empty;
    logic            adv;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] push_result;

    assign last_valid = valid_reg[STAGES-1];
    assign q_full     = (count_reg == CNT_W'(OUT_DEPTH));
    assign q_empty    = (count_reg == '0);
    // A blocked last stage only stalls when the head is not leaving this cycle.
    assign adv        = ~(last_valid & q_full & ~bus.ack);
    assign push       = last_valid & adv;
    assign pop        = bus.ack & ~q_empty;

    assign push_result = (func_reg[STAGES-1] == FUNC_MUL) ? prod_reg[STAGES-1][XLEN-1:0]
                                                          : prod_reg[STAGES-1][PW-1:XLEN];

    assign bus.issue_ready = adv;
    assign bus.done        = ~q_empty;
    assign bus.result      = q_empty ? '0 : q_result_reg[rd_ptr_reg];
    assign bus.rob_tag_out = q_empty ? '0 : q_tag_reg[rd_ptr_reg];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_reg[s]  <= 1'b0;
                tag_reg[s]    <= '0;
                func_reg[s]   <= '0;
                prod_reg[s]   <= '0;
                mcand_reg[s]  <= '0;
                mplier_reg[s] <= '0;
            end
        end else if (bus.squash) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_reg[s] <= 1'b0;
            end
        end else if (adv) begin
            valid_reg[0] <= bus.issue_valid;
            tag_reg[0]   <= bus.rob_tag_in;
            func_reg[0]  <= bus.func;
            for (int s = 1; s < STAGES; s++) begin
                valid_reg[s] <= valid_reg[s-1];
                tag_reg[s]   <= tag_reg[s-1];
                func_reg[s]  <= func_reg[s-1];
            end
            for (int s = 0; s < STAGES; s++) begin
                prod_reg[s]   <= prod_next[s];
                mcand_reg[s]  <= mcand_next[s];
                mplier_reg[s] <= mplier_next[s];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int e = 0; e < OUT_DEPTH; e++) begin
                q_result_reg[e] <= '0;
                q_tag_reg[e]    <= '0;
            end
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (bus.squash) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                q_result_reg[wr_ptr_reg] <= push_result;
                q_tag_reg[wr_ptr_reg]    <= tag_reg[STAGES-1];
                wr_ptr_reg               <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_mult_fu.sv
// Scoreboard bench for mult_fu: expected results are queued at accept and
// compared as the CDB acks each queue head.
module tb_mult_fu;
    localparam int XLEN      = 32;
    localparam int STAGES    = 4;
    localparam int TAG_W     = 5;
    localparam int OUT_DEPTH = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mult_fu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    mult_fu #(
        .XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        logic             chk_lat;
        int               acc_cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sbv, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        case (f)
            2'd1:    p = sa * sbv;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Retire monitor: a head leaves when done & ack and no squash at that edge.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && bus.done && bus.ack && !bus.squash) begin
            if (sb.size() == 0) begin
                check("spurious_done", {63'b0, bus.done}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("result", {32'b0, bus.result}, {32'b0, e.value});
                check("tag", {59'b0, bus.rob_tag_out}, {59'b0, e.tag});
                if (e.chk_lat)
                    check("latency", 64'(cyc - e.acc_cyc), 64'(STAGES));
                $display("retire tag=%0d result=%08h cycle=%0d", bus.rob_tag_out, bus.result, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one operation for one cycle; records it only if it is taken.
    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic [31:0] want,
                         input logic lat, output logic accepted);
        bus.issue_valid = 1'b1;
        bus.func        = f;
        bus.opa         = a;
        bus.opb         = b;
        bus.rob_tag_in  = tag;
        @(negedge clock);
        accepted = bus.issue_ready && !bus.squash;
        if (accepted) sb.push_back('{tag, want, lat, cyc + 1});
        step();
        bus.issue_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        step();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, {63'b0, bus.done}, 64'd0);
        check({tag, "_result"}, {32'b0, bus.result}, 64'd0);
        check({tag, "_tag"}, {59'b0, bus.rob_tag_out}, 64'd0);
        check({tag, "_ready"}, {63'b0, bus.issue_ready}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic acc;
        int n_acc;
        int idx;
        logic [31:0] bp_a [10];
        logic [31:0] bp_b [10];
        logic [1:0]  bp_f [10];

        bus.issue_valid = 1'b0;
        bus.opa         = '0;
        bus.opb         = '0;
        bus.func        = '0;
        bus.rob_tag_in  = '0;
        bus.squash      = 1'b0;
        bus.ack         = 1'b0;

        repeat (3) step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();

        // Single operations with the head acked immediately.
        bus.ack = 1'b1;
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001, 1'b1, acc);
        check("acc_mul", {63'b0, acc}, 64'd1);
        wait_drain(10);
        issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 1'b1, acc);
        wait_drain(10);
        issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 1'b1, acc);
        wait_drain(10);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 1'b1, acc);
        wait_drain(10);
        issue(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 1'b1, acc);
        wait_drain(10);

        // Back-to-back stream; latency check on each implies consecutive retirement.
        for (int i = 1; i <= 8; i++) begin
            issue(2'd0, 32'(i), 32'd3, 5'(i + 8), 32'(i * 3), 1'b1, acc);
            check("stream_ready", {63'b0, acc}, 64'd1);
        end
        wait_drain(20);

        // Back-pressure: no ack, keep presenting until the unit fills.
        for (int i = 0; i < 10; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
            bp_f[i] = 2'($urandom_range(3));
        end
        bus.ack = 1'b0;
        n_acc = 0;
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            issue(bp_f[idx], bp_a[idx], bp_b[idx], 5'(16 + idx),
                  ref_mul(bp_f[idx], bp_a[idx], bp_b[idx]), 1'b0, acc);
            if (acc) begin
                n_acc++;
                idx++;
            end
        end
        check("bp_accepted", 64'(n_acc), 64'(STAGES + OUT_DEPTH));
        check("bp_ready_low", {63'b0, bus.issue_ready}, 64'd0);
        check("bp_done_held", {63'b0, bus.done}, 64'd1);
        bus.ack = 1'b1;
        wait_drain(30);
        check("bp_ready_back", {63'b0, bus.issue_ready}, 64'd1);

        // Squash with three in flight and one queued.
        bus.ack = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(2'd0, 32'(i + 2), 32'd5, 5'(20 + i), 32'((i + 2) * 5), 1'b0, acc);
        step();
        check("sq_pre_done", {63'b0, bus.done}, 64'd1);
        bus.squash      = 1'b1;
        bus.issue_valid = 1'b1;
        bus.ack         = 1'b1;
        bus.func        = 2'd0;
        bus.opa         = 32'd9;
        bus.opb         = 32'd9;
        bus.rob_tag_in  = 5'd30;
        step();
        bus.squash      = 1'b0;
        bus.issue_valid = 1'b0;
        sb.delete();
        check("sq_done_next", {63'b0, bus.done}, 64'd0);
        for (int i = 0; i < STAGES + 2; i++) begin
            step();
            check("sq_quiet", {63'b0, bus.done}, 64'd0);
        end

        // Reset during a stall, then a fresh operation.
        bus.ack = 1'b0;
        idx = 0;
        acc = 1'b1;
        while (acc && idx < 10) begin
            issue(2'd0, 32'(idx + 1), 32'd2, 5'(idx + 1), 32'((idx + 1) * 2), 1'b0, acc);
            idx++;
        end
        check("rst_stalled", {63'b0, bus.issue_ready}, 64'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        sb.delete();
        check_reset_outputs("rst_mid");
        bus.ack = 1'b1;
        issue(2'd0, 32'd7, 32'd6, 5'd9, 32'd42, 1'b1, acc);
        check("rst_acc", {63'b0, acc}, 64'd1);
        wait_drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
